// File: rtl/color_ram_ctrl_if.sv
// rtl/color_ram_ctrl_if.sv - CPU and aux palette-engine request/ack bus into color_ram_ctrl
interface color_ram_ctrl_if;
    logic       cpu_req;
    logic       cpu_we;
    logic [3:0] cpu_addr;
    logic [3:0] cpu_din;
    logic       cpu_ack;
    logic [3:0] cpu_dout;
    logic       aux_req;
    logic [3:0] aux_addr;
    logic [3:0] aux_din;
    logic       aux_ack;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        output aux_req, aux_addr, aux_din,
        input  cpu_ack, cpu_dout, aux_ack
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        input  aux_req, aux_addr, aux_din,
        output cpu_ack, cpu_dout, aux_ack
    );
endinterface

// File: rtl/color_ram_ctrl.sv
// rtl/color_ram_ctrl.sv - palette RAM port-A clear sequencer and CPU/aux round-robin arbiter
// Post-reset clear is built only when COLOR_RAM_CTRL_INIT_EN is defined.
module color_ram_ctrl #(
    parameter logic [3:0] INIT_VAL = 4'h0
) (
    input  logic            clk_a,
    input  logic            reset,
    color_ram_ctrl_if.slave bus,
    output logic [3:0]      ram_addr_o,
    output logic [3:0]      ram_din_o,
    output logic            ram_we_n_o,
    input  logic [3:0]      ram_dout_i,
    output logic            busy_o
);
    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WRITE,
        S_RADDR,
        S_RDATA,
        S_DONE
    } state_t;

`ifdef COLOR_RAM_CTRL_INIT_EN
    localparam state_t RESET_STATE = S_INIT;
`else
    localparam state_t RESET_STATE = S_IDLE;
`endif

    state_t     state_q, state_d;
    logic [3:0] addr_q, addr_d;     // also the clear counter while in S_INIT
    logic [3:0] din_q, din_d;
    logic [3:0] cpu_dout_q, cpu_dout_d;
    logic       grant_aux_q, grant_aux_d;
    logic       last_aux_q, last_aux_d;
    logic       pick_aux;

    always_ff @(posedge clk_a) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            addr_q      <= 4'h0;
            din_q       <= 4'h0;
            cpu_dout_q  <= 4'h0;
            grant_aux_q <= 1'b0;
            last_aux_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            cpu_dout_q  <= cpu_dout_d;
            grant_aux_q <= grant_aux_d;
            last_aux_q  <= last_aux_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        din_d       = din_q;
        cpu_dout_d  = cpu_dout_q;
        grant_aux_d = grant_aux_q;
        last_aux_d  = last_aux_q;
        // On a tie the requester that did not win last time gets the port.
        pick_aux    = (bus.cpu_req && bus.aux_req) ? !last_aux_q : bus.aux_req;

        case (state_q)
            S_INIT: begin
                if (addr_q == 4'hF) begin
                    state_d = S_IDLE;
                end else begin
                    addr_d = addr_q + 4'd1;
                end
            end
            S_IDLE: begin
                if (bus.cpu_req || bus.aux_req) begin
                    grant_aux_d = pick_aux;
                    last_aux_d  = pick_aux;
                    if (pick_aux) begin
                        addr_d  = bus.aux_addr;
                        din_d   = bus.aux_din;
                        state_d = S_WRITE;
                    end else begin
                        addr_d  = bus.cpu_addr;
                        din_d   = bus.cpu_din;
                        state_d = bus.cpu_we ? S_WRITE : S_RADDR;
                    end
                end
            end
            S_WRITE: state_d = S_DONE;
            S_RADDR: state_d = S_RDATA;
            S_RDATA: begin
                cpu_dout_d = ram_dout_i;
                state_d    = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = RESET_STATE;
        endcase
    end

    assign ram_addr_o   = addr_q;
    assign ram_din_o    = (state_q == S_INIT) ? INIT_VAL : din_q;
    assign ram_we_n_o   = !((state_q == S_INIT) || (state_q == S_WRITE));
    assign bus.cpu_ack  = (state_q == S_DONE) && !grant_aux_q;
    assign bus.aux_ack  = (state_q == S_DONE) && grant_aux_q;
    assign bus.cpu_dout = cpu_dout_q;

`ifdef COLOR_RAM_CTRL_INIT_EN
    assign busy_o = (state_q == S_INIT);
`else
    assign busy_o = 1'b0;
`endif
endmodule
